// File: rtl/fft_frame_seq.sv
// fft_frame_seq: sequences one FFT frame: pushes a fixed number of samples in, drains a fixed number of results out.
//
// Ports:
//   hclk, rst_n                          clock, asynchronous active-low reset
//   start, abort, cfg_cont               control: begin sequence (IDLE only), abort (any state), auto-restart
//   cfg_frame_len, cfg_n_need            samples pushed / results collected per frame
//   src_data/src_valid/src_ready         sample stream in from the ADC buffer
//   fft_data_in/fft_valid_in/fft_ready_out   sample stream out to the FFT
//   fft_data_out/fft_valid_out/fft_ready_in  result stream in from the FFT
//   dst_data/dst_valid/dst_ready         result stream out to the mel stage
//   busy, done, err, frame_cnt           status: active, frame-complete pulse, error pulse, completed frames
//
// Build option: define FFT_SEQ_TIMEOUT_EN to abandon a DRAIN that stalls for TO_CYC cycles.
module fft_frame_seq #(
   parameter int DW     = 32,
   parameter int LW     = 10,
   parameter int TO_CYC = 4096
) (
   input  logic          hclk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          cfg_cont,
   input  logic [LW-1:0] cfg_frame_len,
   input  logic [7:0]    cfg_n_need,
   input  logic [DW-1:0] src_data,
   input  logic          src_valid,
   output logic          src_ready,
   output logic [DW-1:0] fft_data_in,
   output logic          fft_valid_in,
   input  logic          fft_ready_out,
   input  logic [DW-1:0] fft_data_out,
   input  logic          fft_valid_out,
   output logic          fft_ready_in,
   output logic [DW-1:0] dst_data,
   output logic          dst_valid,
   input  logic          dst_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [15:0]   frame_cnt
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   if (TO_CYC < 2) begin : g_to_chk
      $error("fft_frame_seq: TO_CYC must be at least 2");
   end
   state_t        state_q, state_d;
   logic [LW-1:0] in_cnt_q, in_cnt_d, len_q, len_d;
   logic [7:0]    out_cnt_q, out_cnt_d, need_q, need_d;
   logic          cont_q, cont_d, done_q, done_d, err_q, err_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          in_hs, out_hs, latch;
`ifdef FFT_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif
   assign fft_data_in  = src_data;
   assign fft_valid_in = (state_q == LOAD) && src_valid;
   assign src_ready    = (state_q == LOAD) && fft_ready_out;
   assign dst_data     = fft_data_out;
   assign dst_valid    = (state_q == DRAIN) && fft_valid_out;
   assign fft_ready_in = (state_q == DRAIN) && dst_ready;
   assign in_hs        = fft_valid_in && src_ready;
   assign out_hs       = dst_valid && fft_ready_in;
   assign busy         = state_q != IDLE;
   assign done         = done_q;
   assign err          = err_q;
   assign frame_cnt    = frame_cnt_q;
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      err_d     = 1'b0;
      latch     = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
      to_cnt_d  = (state_q == DRAIN && !out_hs) ? to_cnt_q + TW'(1) : '0;
`endif
      case (state_q)
         IDLE: begin
            if (start && cfg_frame_len != '0) begin
               state_d = LOAD;
               latch   = 1'b1;
            end else if (start) begin
               err_d = 1'b1;
            end
         end
         LOAD: begin
            if (in_hs) begin
               in_cnt_d = (in_cnt_q == len_q - LW'(1)) ? '0 : in_cnt_q + LW'(1);
               if (in_cnt_q == len_q - LW'(1)) state_d = (need_q == 8'd0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               out_cnt_d = (out_cnt_q == need_q - 8'd1) ? '0 : out_cnt_q + 8'd1;
               if (out_cnt_q == need_q - 8'd1) state_d = DONE;
            end
`ifdef FFT_SEQ_TIMEOUT_EN
            else if (to_cnt_q == TW'(TO_CYC - 1)) begin
               state_d   = IDLE;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               err_d     = 1'b1;
            end
`endif
         end
         default: begin
            // Continuous mode re-latches the config for the next frame on DONE->LOAD.
            state_d = cont_q ? LOAD : IDLE;
            latch   = cont_q;
         end
      endcase
      // Abort overrides every transition above, including a frame completing this cycle.
      if (abort) begin
         state_d   = IDLE;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         err_d     = 1'b0;
         latch     = 1'b0;
      end
      len_d       = latch ? cfg_frame_len : len_q;
      need_d      = latch ? cfg_n_need : need_q;
      cont_d      = latch ? cfg_cont : cont_q;
      done_d      = state_d == DONE;
      frame_cnt_d = frame_cnt_q + 16'(done_d);
   end
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         len_q       <= '0;
         need_q      <= '0;
         cont_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         len_q       <= len_d;
         need_q      <= need_d;
         cont_q      <= cont_d;
         done_q      <= done_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef FFT_SEQ_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: directed self-checking bench for fft_frame_seq (default build).
module tb_fft_frame_seq;
   logic        hclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, cfg_cont = 1'b0;
   logic [9:0]  cfg_frame_len = '0;
   logic [7:0]  cfg_n_need = '0;
   logic [31:0] src_data = '0, fft_data_out = '0;
   logic        src_valid = 1'b0, fft_ready_out = 1'b0, fft_valid_out = 1'b0, dst_ready = 1'b0;
   logic        src_ready, fft_valid_in, fft_ready_in, dst_valid, busy, done, err;
   logic [31:0] fft_data_in, dst_data;
   logic [15:0] frame_cnt;
   int          n_cmp = 0, n_err = 0;
   int          in_beats, out_beats, done_cnt, err_cnt;
   logic [31:0] in_q[$], out_q[$];

   fft_frame_seq dut (
      .hclk(hclk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_cont(cfg_cont),
      .cfg_frame_len(cfg_frame_len), .cfg_n_need(cfg_n_need),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .fft_data_in(fft_data_in), .fft_valid_in(fft_valid_in), .fft_ready_out(fft_ready_out),
      .fft_data_out(fft_data_out), .fft_valid_out(fft_valid_out), .fft_ready_in(fft_ready_in),
      .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
      .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      in_beats = 0; out_beats = 0; done_cnt = 0; err_cnt = 0;
      in_q.delete(); out_q.delete();
   endtask

   // One clock: note handshakes before the edge, advance the sources after it.
   task automatic tick();
      logic ih, oh;
      #1;
      ih = fft_valid_in && fft_ready_out;
      oh = dst_valid && dst_ready;
      if (ih) in_q.push_back(fft_data_in);
      if (oh) out_q.push_back(dst_data);
      @(posedge hclk);
      #1;
      if (ih) begin in_beats++; src_data = src_data + 32'd1; end
      if (oh) begin out_beats++; fft_data_out = fft_data_out + 32'd1; end
      if (done) done_cnt++;
      if (err) err_cnt++;
   endtask

   initial begin
      int n, bad;
      clr();
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_dst_valid", dst_valid, 0);
      rst_n = 1'b1;
      // Basic frame: len 4, need 2, everything ready.
      cfg_frame_len = 10'd4; cfg_n_need = 8'd2; cfg_cont = 1'b0;
      src_valid = 1; fft_ready_out = 1; fft_valid_out = 1; dst_ready = 1;
      src_data = 32'hA0; fft_data_out = 32'hB0;
      tick();
      chk("idle_fft_valid", fft_valid_in, 0);
      chk("idle_fft_ready_in", fft_ready_in, 0);
      start = 1; tick(); start = 0;
      chk("load_busy", busy, 1);
      chk("load_src_ready", src_ready, 1);
      repeat (4) tick();
      chk("drain_dst_valid", dst_valid, 1);
      chk("drain_src_ready", src_ready, 0);
      repeat (2) tick();
      chk("b_done", done, 1);
      chk("b_frame_cnt", frame_cnt, 1);
      chk("b_in_beats", in_beats, 4);
      chk("b_out_beats", out_beats, 2);
      chk("b_in_first", in_q[0], 32'hA0);
      chk("b_in_last", in_q[3], 32'hA3);
      chk("b_out_last", out_q[1], 32'hB1);
      tick();
      chk("b_done_clr", done, 0);
      chk("b_busy_after", busy, 0);
      chk("b_done_cnt", done_cnt, 1);
      // Stalled frame: len 256, need 128, fixed irregular stall patterns.
      clr();
      cfg_frame_len = 10'd256; cfg_n_need = 8'd128;
      src_data = 32'h1000; fft_data_out = 32'h2000;
      start = 1; tick(); start = 0;
      n = 0;
      while (done_cnt < 1 && n < 5000) begin
         src_valid = (n % 3) != 0; fft_ready_out = (n % 5) != 1;
         fft_valid_out = (n % 7) != 3; dst_ready = (n % 4) != 2;
         tick(); n++;
      end
      chk("s_done_seen", done_cnt, 1);
      chk("s_in_beats", in_beats, 256);
      chk("s_out_beats", out_beats, 128);
      bad = 0;
      foreach (in_q[i]) if (in_q[i] !== 32'h1000 + 32'(i)) bad++;
      foreach (out_q[i]) if (out_q[i] !== 32'h2000 + 32'(i)) bad++;
      chk("s_order_errs", bad, 0);
      chk("s_frame_cnt", frame_cnt, 2);
      // Continuous mode: three frames then abort.
      src_valid = 1; fft_ready_out = 1; fft_valid_out = 1; dst_ready = 1;
      rst_n = 0; tick(); tick(); rst_n = 1;
      clr();
      cfg_frame_len = 10'd8; cfg_n_need = 8'd4; cfg_cont = 1'b1;
      start = 1; tick(); start = 0;
      n = 0;
      while (done_cnt < 1 && n < 100) begin tick(); n++; end
      chk("c_first_done", done_cnt, 1);
      tick();
      chk("c_reload_src_ready", src_ready, 1);
      chk("c_reload_busy", busy, 1);
      while (done_cnt < 3 && n < 300) begin tick(); n++; end
      chk("c_three_done", done_cnt, 3);
      chk("c_frame_cnt", frame_cnt, 3);
      chk("c_in_beats", in_beats, 24);
      tick();
      abort = 1; tick(); abort = 0;
      chk("c_abort_busy", busy, 0);
      chk("c_abort_valid", fft_valid_in, 0);
      repeat (40) tick();
      chk("c_no_4th_done", done_cnt, 3);
      chk("c_frame_cnt_kept", frame_cnt, 3);
      // Zero-length start, then zero results.
      clr();
      cfg_cont = 0; cfg_frame_len = 10'd0;
      start = 1; tick();
      chk("z_err", err, 1);
      chk("z_busy", busy, 0);
      start = 0; tick();
      chk("z_err_clr", err, 0);
      chk("z_err_cnt", err_cnt, 1);
      cfg_frame_len = 10'd3; cfg_n_need = 8'd0;
      start = 1; tick(); start = 0;
      repeat (3) tick();
      chk("n0_done", done, 1);
      chk("n0_frame_cnt", frame_cnt, 4);
      chk("n0_out_beats", out_beats, 0);
      tick();
      chk("n0_busy_after", busy, 0);
      // Reset mid-load.
      clr();
      cfg_frame_len = 10'd4; cfg_n_need = 8'd2;
      start = 1; tick(); start = 0;
      tick();
      chk("r_busy_pre", busy, 1);
      rst_n = 0; #1;
      chk("r_busy", busy, 0);
      chk("r_src_ready", src_ready, 0);
      chk("r_fft_valid", fft_valid_in, 0);
      chk("r_frame_cnt", frame_cnt, 0);
      tick(); rst_n = 1;
      repeat (10) tick();
      chk("r_no_done", done_cnt, 0);
      chk("r_busy_after", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
